// File: rtl/adder_pkg.sv
// adder_pkg: shared FSM state type and slice width for the nibble-serial adder
package adder_pkg;
   localparam int SLICE_W = 4;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/parallel_adder.sv
// parallel_adder: 4-bit ripple-carry adder (a, b, cin -> sum, cout)
module parallel_adder
   import adder_pkg::*;
(
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               cin,
   output logic [SLICE_W-1:0] sum,
   output logic               cout
);
   logic c;
   always_comb begin
      sum = '0;
      c = cin;
      for (int i = 0; i < SLICE_W; i++) begin
         sum[i] = a[i] ^ b[i] ^ c;
         c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: adds two W=4*NIBBLES operands one nibble per clock.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/a/b/cin operand request;
// out_valid/out_ready/sum/cout result; busy high while slices are being added.
// Optional NIBBLE_SERIAL_ADDER_SAT_EN: sum saturates to all ones on final carry.
module nibble_serial_adder
   import adder_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [SLICE_W*NIBBLES-1:0] a,
   input  logic [SLICE_W*NIBBLES-1:0] b,
   input  logic                    cin,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [SLICE_W*NIBBLES-1:0] sum,
   output logic                    cout,
   output logic                    busy
);
   localparam int W  = SLICE_W * NIBBLES;
   localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
   state_t state, state_d;
   logic [IW-1:0] idx;
   logic [W-1:0] a_q, b_q, sum_q;
   logic carry_q, cout_q, last, c_slice;
   logic [SLICE_W-1:0] s_slice;
   assign last = idx == IW'(NIBBLES - 1);
   parallel_adder u_slice (
      .a   (a_q[SLICE_W*idx +: SLICE_W]),
      .b   (b_q[SLICE_W*idx +: SLICE_W]),
      .cin (carry_q),
      .sum (s_slice),
      .cout(c_slice)
   );
   always_comb begin
      state_d = state;
      case (state)
         IDLE:    state_d = in_valid ? RUN : IDLE;
         RUN:     state_d = last ? DONE : RUN;
         DONE:    state_d = out_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_d;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         idx     <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               a_q     <= a;
               b_q     <= b;
               carry_q <= cin;
               idx     <= '0;
               sum_q   <= '0;
               cout_q  <= 1'b0;
            end
            RUN: begin
               sum_q[SLICE_W*idx +: SLICE_W] <= s_slice;
               carry_q <= c_slice;
               // idx returns to 0 on the last slice so it never wraps past NIBBLES-1
               idx <= last ? '0 : idx + IW'(1);
               if (last) begin
                  cout_q <= c_slice;
`ifdef NIBBLE_SERIAL_ADDER_SAT_EN
                  // later assignment overrides the slice write above
                  if (c_slice) sum_q <= '1;
`endif
               end
            end
            default: ;
         endcase
      end
   end
   assign in_ready  = state == IDLE;
   assign busy      = state == RUN;
   assign out_valid = state == DONE;
   assign sum       = sum_q;
   assign cout      = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: table-driven, scoreboarded check of nibble_serial_adder
module tb_nibble_serial_adder;
   localparam int NIBBLES = 4;
   localparam int W = 4 * NIBBLES;
   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] exp_sum;
      logic         exp_cout;
   } vec_t;
   typedef struct {
      logic [W-1:0] s;
      logic         c;
   } exp_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0;
   logic in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic cin = 1'b0;
   logic out_valid;
   logic out_ready = 1'b0;
   logic [W-1:0] sum;
   logic cout;
   logic busy;
   int checks = 0;
   int errors = 0;
   exp_t sb[$];
   vec_t vecs[8];
   nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sum      (sum),
      .cout     (cout),
      .busy     (busy)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask
   function automatic exp_t expect_of(input logic [W-1:0] s, input logic c);
      exp_t e;
      e.c = c;
`ifdef NIBBLE_SERIAL_ADDER_SAT_EN
      e.s = c ? '1 : s;
`else
      e.s = s;
`endif
      return e;
   endfunction
   // Accept one operation, measure latency, optionally stall in DONE, then consume.
   // With pend set, a competing request is held on in_valid during the stall.
   task automatic do_op(input vec_t v, input int hold, input bit pend);
      int n;
      exp_t e, got;
      logic [W-1:0] held_sum;
      logic held_cout;
      e = expect_of(v.exp_sum, v.exp_cout);
      in_valid = 1'b1;
      a = v.a;
      b = v.b;
      cin = v.cin;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("in_ready_before_accept", 32'(in_ready), 32'd1);
      @(posedge clk);
      sb.push_back(e);
      #1;
      in_valid = 1'b0;
      chk("busy_in_run", 32'(busy), 32'd1);
      n = 0;
      while (!out_valid && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("latency", 32'(n), 32'(NIBBLES));
      held_sum = sum;
      held_cout = cout;
      repeat (hold) begin
         if (pend) begin
            in_valid = 1'b1;
            a = 16'hAAAA;
            b = 16'h5555;
         end
         @(posedge clk);
         #1;
         chk("stall_out_valid", 32'(out_valid), 32'd1);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         chk("stall_sum", 32'(sum), 32'(held_sum));
         chk("stall_cout", 32'(cout), 32'(held_cout));
      end
      out_ready = 1'b1;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
         got = sb.pop_front();
         chk("sum", 32'(sum), 32'(got.s));
         chk("cout", 32'(cout), 32'(got.c));
      end
      chk("in_ready_while_consume", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("out_valid_after_consume", 32'(out_valid), 32'd0);
      chk("in_ready_after_consume", 32'(in_ready), 32'd1);
   endtask
   initial begin
      vec_t v;
      int seen;
      vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
      vecs[1] = '{16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0};
      vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
      vecs[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
      vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
      vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
      vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
      vecs[7] = '{16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0};
      #12;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) do_op(vecs[i], 0, 1'b0);
      // stall in DONE with a competing request that must wait until after consume
      do_op(vecs[0], 3, 1'b1);
      chk("pending_not_accepted", 32'(busy), 32'd0);
      v = '{16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0};
      do_op(v, 0, 1'b0);
      // reset two cycles into RUN aborts the operation
      in_valid = 1'b1;
      a = 16'h1111;
      b = 16'h2222;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      sb.delete();
      #1;
      chk("midrun_rst_in_ready", 32'(in_ready), 32'd1);
      chk("midrun_rst_busy", 32'(busy), 32'd0);
      chk("midrun_rst_sum", 32'(sum), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("released_in_ready", 32'(in_ready), 32'd1);
      seen = 0;
      repeat (8) begin
         @(posedge clk);
         #1;
         if (out_valid) seen++;
      end
      chk("no_out_valid_after_abort", 32'(seen), 32'd0);
      v = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0};
      do_op(v, 0, 1'b0);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 SHALL have parameter NIBBLES, default 4: number of 4-bit slices; operand width W = 4*NIBBLES.
REQ-002 SHALL have port clk  input  1: single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1: operand request valid.
REQ-005 SHALL have port in_ready  output  1: block can accept operands.
REQ-006 SHALL have port a  input  W: operand A, unsigned.
REQ-007 SHALL have port b  input  W: operand B, unsigned.
REQ-008 SHALL have port cin  input  1: carry into nibble 0.
REQ-009 SHALL have port out_valid  output  1: result valid.
REQ-010 SHALL have port out_ready  input  1: consumer accepts result.
REQ-011 SHALL have port sum  output  W: result.
REQ-012 SHALL have port cout  output  1: carry out of the top nibble.
REQ-013 SHALL have port busy  output  1: high in RUN.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 SHALL assert in_ready only in IDLE, combinationally from state.
REQ-016 SHALL accept on an edge where in_valid && in_ready: latch a, b, cin into operand registers, clear the slice index to 0, go to RUN.
REQ-017 SHALL, in RUN, add slice idx of A and B plus the carry register through one 4-bit adder; at each edge, write the 4-bit result into sum[4*idx+:4], store the adder carry in the carry register, and increment idx.
REQ-018 SHALL use the latched cin as the carry into slice 0; slice k>0 takes the carry from slice k-1.
REQ-019 SHALL go RUN -> DONE on the edge that processes idx == NIBBLES-1; out_valid rises exactly NIBBLES edges after the accepting edge.
REQ-020 SHALL hold sum, cout and out_valid stable in DONE until out_valid && out_ready, then go DONE -> IDLE on that edge.
REQ-021 SHALL keep in_ready low in the cycle a result is being consumed; a new accept happens at the earliest one cycle later (no overlap).
REQ-022 SHALL ignore in_valid outside IDLE and ignore out_ready outside DONE.
REQ-023 SHALL produce, without saturation, sum = (a + b + cin) mod 2^W and cout = bit W of a + b + cin.
REQ-024 SHALL keep idx wide enough for NIBBLES-1, with no wrap inside RUN.

Reset
REQ-025 SHALL, while rst_n is low, force state IDLE, idx 0, the carry register 0 and all operand registers 0.
REQ-026 SHALL, while rst_n is low, force outputs to in_ready 1, out_valid 0, busy 0, sum 0, cout 0.
REQ-027 SHALL abort an operation when reset is asserted mid-RUN or mid-DONE; the result is discarded and no out_valid follows after release.

Configuration
REQ-028 SHALL, when macro NIBBLE_SERIAL_ADDER_SAT_EN is defined, load sum with all ones on entry to DONE whenever the final carry is 1; cout still reports 1.
REQ-029 SHALL, when NIBBLE_SERIAL_ADDER_SAT_EN is undefined, produce the modulo result per REQ-023 with no saturation logic present.

Structure
REQ-030 SHALL place the FSM state enum and the 4-bit slice width constant in shared package adder_pkg.
REQ-031 SHALL instantiate the team's existing 4-bit ripple adder, parallel_adder, once as the only sub-module for the slice datapath.

Verification
REQ-032 SHALL cover: a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0, out_valid 4 edges after accept.
REQ-033 SHALL cover: a=0x0FFF, b=0x0000, cin=1 -> sum=0x1000, cout=0 (carry ripples across three slices).
REQ-034 SHALL cover: a=0xFFFF, b=0x0001, cin=0 -> cout=1; sum=0x0000 without the macro, 0xFFFF with NIBBLE_SERIAL_ADDER_SAT_EN.
REQ-035 SHALL cover: out_ready held low 3 cycles in DONE -> sum and cout stable, in_ready=0, second in_valid not accepted until one cycle after consume.
REQ-036 SHALL cover: rst_n pulsed low 2 cycles after accept -> out_valid stays 0, in_ready=1 after release, next operation a=0x0001, b=0x0001 -> sum=0x0002.
